// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM plus memory-mapped LED, timer and UART transmitter
module dmem_mmio #(
    parameter int RAM_WORDS    = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic [7:0]  led,
    output logic        uart_tx
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   DEPTH    = (PW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic [31:0]   timer;

    uart_state_t   state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic [AW-1:0] ram_idx;
    logic sel_ram, sel_io, sel_led, sel_tmr, sel_data, sel_stat;
    logic wr_stat, push_req, push_ok, pop, bit_end, fifo_empty, fifo_full, busy;
    logic unused_addr_bits;

    assign unused_addr_bits = ^ALUResultM[1:0];

    assign ram_idx  = ALUResultM[AW+1:2];
    assign sel_ram  = (ALUResultM[31:AW+2] == '0);
    assign sel_io   = (ALUResultM[31:4] == 28'hFFFF000);
    assign sel_led  = sel_io && (ALUResultM[3:2] == 2'd0);
    assign sel_tmr  = sel_io && (ALUResultM[3:2] == 2'd1);
    assign sel_data = sel_io && (ALUResultM[3:2] == 2'd2);
    assign sel_stat = sel_io && (ALUResultM[3:2] == 2'd3);

    assign wr_stat    = MemWriteM && sel_stat;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH);
    assign busy       = (state != S_IDLE);
    assign bit_end    = (clk_cnt == BIT_LAST);

    // The transmitter pops when leaving IDLE or at the last STOP cycle, so frames chain without a gap.
    assign pop      = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign push_req = MemWriteM && sel_data;
    assign push_ok  = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (MemWriteM && sel_ram) begin
            ram[ram_idx] <= WriteDataM;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= WriteDataM[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped byte on the same edge as a clear leaves the flag set.
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (wr_stat && WriteDataM[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led   <= 8'h00;
            timer <= 32'h0;
        end else begin
            if (MemWriteM && sel_led) begin
                led <= WriteDataM[7:0];
            end
            if (MemWriteM && sel_tmr) begin
                timer <= WriteDataM;
            end else begin
                timer <= timer + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    uart_tx <= 1'b1;
                    if (pop) begin
                        state   <= S_START;
                        shreg   <= fifo_mem[rd_ptr];
                        uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        uart_tx <= shreg[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (pop) begin
                            state   <= S_START;
                            shreg   <= fifo_mem[rd_ptr];
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= S_IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ReadDataM = 32'h0;
        if (sel_ram) begin
            ReadDataM = ram[ram_idx];
        end else if (sel_io) begin
            case (ALUResultM[3:2])
                2'd0:    ReadDataM = {24'h0, led};
                2'd1:    ReadDataM = timer;
                2'd2:    ReadDataM = 32'h0;
                default: ReadDataM = {28'h0, overflow, busy, fifo_empty, fifo_full};
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - scoreboard bench for dmem_mmio against a frame-level reference model
module tb_dmem_mmio;
    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = 4;
    localparam int FRAME      = 10 * CPB;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_TMR  = 32'hFFFF_0004;
    localparam logic [31:0] A_DATA = 32'hFFFF_0008;
    localparam logic [31:0] A_STAT = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [31:0] ReadDataM;
    logic [7:0]  led;
    logic        uart_tx;

    dmem_mmio #(
        .RAM_WORDS   (RAM_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .ReadDataM (ReadDataM),
        .led       (led),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] addr;
        logic [7:0]  led;
        logic        tx;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_ram [RAM_WORDS];
    logic [7:0]  m_led;
    logic [31:0] m_tmr;
    logic [7:0]  m_q[$];
    logic [7:0]  m_byte;
    bit          m_ovf;
    bit          m_busy;
    int          m_rem;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'(RAM_WORDS * 4)) return m_ram[int'(w >> 2)];
        if (w == A_LED)  return {24'h0, m_led};
        if (w == A_TMR)  return m_tmr;
        if (w == A_STAT) return {28'h0, m_ovf, m_busy, m_q.size() == 0, m_q.size() == FIFO_DEPTH};
        return 32'h0;
    endfunction

    // Line level derived from how far into the current 10-bit frame we are.
    function automatic logic exp_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = (FRAME - m_rem) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_led  = 8'h00;
        m_tmr  = 32'h0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_rem  = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        bit pop, ovf_set, ovf_clr;
        w = {ALUResultM[31:2], 2'b00};
        pop = (m_q.size() > 0) && (!m_busy || m_rem == 1);
        ovf_set = 1'b0;
        ovf_clr = 1'b0;
        if (MemWriteM && w == A_TMR) m_tmr = WriteDataM;
        else m_tmr = m_tmr + 32'd1;
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) m_busy = 1'b0;
        end
        if (MemWriteM) begin
            if (w < 32'(RAM_WORDS * 4)) m_ram[int'(w >> 2)] = WriteDataM;
            if (w == A_LED) m_led = WriteDataM[7:0];
            if (w == A_DATA) begin
                if (m_q.size() < FIFO_DEPTH || pop) m_q.push_back(WriteDataM[7:0]);
                else ovf_set = 1'b1;
            end
            if (w == A_STAT && WriteDataM[3]) ovf_clr = 1'b1;
        end
        if (pop) begin
            m_byte = m_q.pop_front();
            m_busy = 1'b1;
            m_rem  = FRAME;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic cycle(input logic rst, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        if (reset) model_step();
        #1;
        reset      = rst;
        MemWriteM  = we;
        ALUResultM = a;
        WriteDataM = d;
        if (!rst) model_reset();
        e.rd   = m_read(a);
        e.addr = a;
        e.led  = m_led;
        e.tx   = exp_tx();
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cycle(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle(input int n, input logic [31:0] a);
        for (int i = 0; i < n; i++) rd(a);
    endtask

    task automatic check(input string name, input logic [31:0] addr, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s addr=%h: got %h required %h at %0t", name, addr, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ReadDataM", e.addr, ReadDataM, e.rd);
            check("led", e.addr, {24'h0, led}, {24'h0, e.led});
            check("uart_tx", e.addr, {31'h0, uart_tx}, {31'h0, e.tx});
        end
    end

    initial begin
        int r;
        logic [31:0] a;
        model_reset();
        repeat (3) cycle(1'b0, 1'b0, A_STAT, 32'h0);
        cycle(1'b1, 1'b0, A_TMR, 32'h0);
        idle(3, A_TMR);
        idle(2, A_STAT);

        for (int i = 0; i < RAM_WORDS; i++) wr(32'(i * 4), $urandom);

        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010);
        rd(32'h0000_0014);
        rd(32'h1234_0000);
        wr(A_LED, 32'h0000_01A5);
        rd(A_LED);
        wr(A_TMR, 32'hFFFF_FFFE);
        idle(3, A_TMR);

        wr(A_DATA, 32'h0000_0055);
        idle(44, A_STAT);

        for (int i = 1; i <= 6; i++) wr(A_DATA, 32'(i));
        idle(205, A_STAT);
        wr(A_STAT, 32'h0000_0008);
        idle(2, A_STAT);

        wr(A_DATA, 32'h0000_00A3);
        wr(A_DATA, 32'h0000_003C);
        idle(20, A_STAT);
        cycle(1'b0, 1'b0, A_STAT, 32'h0);
        cycle(1'b0, 1'b0, A_STAT, 32'h0);
        cycle(1'b1, 1'b0, A_STAT, 32'h0);
        idle(60, A_STAT);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1: wr(32'($urandom_range(0, RAM_WORDS - 1) * 4), $urandom);
                2:    rd(32'($urandom_range(0, RAM_WORDS - 1) * 4) | 32'($urandom_range(0, 3)));
                3:    if ($urandom_range(0, 1) == 1) wr(A_LED, $urandom); else rd(A_LED);
                4:    if ($urandom_range(0, 2) == 0) wr(A_TMR, 32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
                      else if ($urandom_range(0, 1) == 1) wr(A_TMR, $urandom);
                      else rd(A_TMR);
                5:    wr(A_DATA, $urandom);
                6, 7: rd(A_STAT);
                8:    wr(A_STAT, $urandom);
                9: begin
                    a = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
                    if ($urandom_range(0, 1) == 1) wr(a, $urandom); else rd(a);
                end
                10: begin
                    a = 32'hFFFF_0010 + 32'($urandom_range(0, 15) * 4);
                    if ($urandom_range(0, 1) == 1) wr(a, $urandom); else rd(a);
                end
                default: rd(A_DATA);
            endcase
        end
        idle(FRAME * (FIFO_DEPTH + 2), A_STAT);

        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
